// File: rtl/ble_sync_frame_fifo.sv
// Single-clock BLE frame FIFO: level/threshold status, sticky errors, frame-done tracking, direct peek reads.
// Reads return one cycle after R_inc; writes to a full FIFO and pops from an empty one are dropped and flagged.
module ble_sync_frame_fifo #(
  parameter int AD     = 8,
  parameter int DATA   = 32,
  parameter int SIZE_W = 17
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              W_inc,
  input  logic [DATA-1:0]   W_Data,
  input  logic              R_inc,
  input  logic              mode,
  input  logic [AD-1:0]     fifo_address,
  input  logic              tx_irq,
  input  logic [SIZE_W-1:0] data_size,
  input  logic [AD:0]       af_level,
  input  logic [AD:0]       ae_level,
  output logic [DATA-1:0]   R_Data,
  output logic              R_valid,
  output logic [AD-1:0]     r_addr_fifo,
  output logic [AD:0]       level,
  output logic              Full,
  output logic              Empty,
  output logic              Almost_full,
  output logic              Almost_empty,
  output logic              overflow,
  output logic              underflow,
  output logic              w_done_flag,
  output logic              r_done_flag
);

  localparam int LB = $clog2(DATA);
  localparam int BW = SIZE_W + LB;
  localparam logic [AD:0] DEPTH = {1'b1, {AD{1'b0}}};

  logic [DATA-1:0]   mem_q [2**AD];
  logic [AD:0]       wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
  logic              full_q, empty_q;
  logic              ovf_q, ovf_d, unf_q, unf_d, rvld_q, rvld_d;
  logic [DATA-1:0]   rdata_q, rdata_d;
  logic [SIZE_W-1:0] wr_words_q, wr_words_d, rd_words_q, rd_words_d;
  logic              wdone_q, wdone_d, rdone_q, rdone_d;
  logic              wr_acc, rd_acc, pk_acc, size_nz;
  logic [BW-1:0]     wr_bits, rd_bits, size_ext;
  logic [AD-1:0]     rd_addr;

  assign rd_addr = mode ? fifo_address : rptr_q[AD-1:0];

  always_comb begin
    wr_acc     = W_inc & ~full_q & ~tx_irq;
    rd_acc     = R_inc & ~mode & ~empty_q & ~tx_irq;
    pk_acc     = R_inc & mode & ~tx_irq;
    size_nz    = (data_size != '0);
    size_ext   = BW'(data_size);
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    rvld_d     = 1'b0;
    rdata_d    = rdata_q;
    wr_words_d = wr_words_q;
    rd_words_d = rd_words_q;
    wdone_d    = wdone_q;
    rdone_d    = rdone_q;
    if (tx_irq) begin
      wptr_d     = '0;
      rptr_d     = '0;
      ovf_d      = 1'b0;
      unf_d      = 1'b0;
      wr_words_d = '0;
      rd_words_d = '0;
      wdone_d    = 1'b0;
      rdone_d    = 1'b0;
    end else begin
      if (W_inc & full_q) ovf_d = 1'b1;
      // A write into an empty FIFO masks the simultaneous pop attempt.
      if (R_inc & ~mode & empty_q & ~W_inc) unf_d = 1'b1;
      if (rd_acc | pk_acc) begin
        rvld_d  = 1'b1;
        rdata_d = mem_q[rd_addr];
      end
      if (rd_acc) begin
        rptr_d = rptr_q + (AD+1)'(1);
        if (rd_words_q != '1) rd_words_d = rd_words_q + SIZE_W'(1);
      end
      if (wr_acc) begin
        wptr_d = wptr_q + (AD+1)'(1);
        if (wr_words_q != '1) wr_words_d = wr_words_q + SIZE_W'(1);
      end
    end
    wr_bits = BW'(wr_words_d) << LB;
    rd_bits = BW'(rd_words_d) << LB;
    if (!tx_irq) begin
      if (rd_acc && size_nz && rd_bits >= size_ext) rdone_d = 1'b1;
      // Once the frame is fully drained, re-arm the write side for the next frame.
      if (wr_acc && size_nz && wr_bits >= size_ext) wdone_d = 1'b1;
      else if (rdone_q && empty_q)                  wdone_d = 1'b0;
    end
    level_d = wptr_d - rptr_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rvld_q     <= 1'b0;
      rdata_q    <= '0;
      wr_words_q <= '0;
      rd_words_q <= '0;
      wdone_q    <= 1'b0;
      rdone_q    <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      full_q     <= (level_d == DEPTH);
      empty_q    <= (level_d == '0);
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rvld_q     <= rvld_d;
      rdata_q    <= rdata_d;
      wr_words_q <= wr_words_d;
      rd_words_q <= rd_words_d;
      wdone_q    <= wdone_d;
      rdone_q    <= rdone_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_acc) mem_q[wptr_q[AD-1:0]] <= W_Data;
  end

  assign R_Data       = rdata_q;
  assign R_valid      = rvld_q;
  assign r_addr_fifo  = rd_addr;
  assign level        = level_q;
  assign Full         = full_q;
  assign Empty        = empty_q;
  assign Almost_full  = (level_q >= af_level);
  assign Almost_empty = (level_q <= ae_level);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign w_done_flag  = wdone_q;
  assign r_done_flag  = rdone_q;

endmodule

// File: doc/ble_sync_frame_fifo.md
# ble_sync_frame_fifo

Single-clock, parametrised frame FIFO for the BLE PHY datapath. It is the next-generation replacement for the dual-clock BLE FIFO where PHY and bus share one clock. It generalises width and depth and adds the following:
- occupancy level output
- programmable almost-full/almost-empty thresholds
- sticky overflow/underflow errors
- frame-done tracking on both write and read sides against a bit-size target
- direct-address "peek" read mode that leaves the read pointer untouched

It sits between the AHB slave (CPU side) and the BLE modulator/demodulator stream (PHY side).

## Interface
Parameters:
- AD, 8, address width; depth = 2^AD words
- DATA, 32, word width in bits; must be a power of two
- SIZE_W, 17, width of frame size and bit counters

Ports:
- CLK  in  1  single clock, all logic on rising edge
- RST  in  1  reset, asynchronous, active-high
- W_inc  in  1  write request
- W_Data  in  DATA  write word
- R_inc  in  1  read request (pop in stream mode, peek in direct mode)
- mode  in  1  0 = stream read via read pointer; 1 = direct read at fifo_address
- fifo_address  in  AD  direct read address (mode = 1)
- tx_irq  in  1  synchronous frame restart/flush
- data_size  in  SIZE_W  frame length in bits; 0 disables done flags
- af_level  in  AD+1  almost-full threshold
- ae_level  in  AD+1  almost-empty threshold
- R_Data  out  DATA  registered read word
- R_valid  out  1  R_Data valid this cycle
- r_addr_fifo  out  AD  memory address used by the current read
- level  out  AD+1  words stored
- Full, Empty, Almost_full, Almost_empty  out  1  status
- overflow, underflow  out  1  sticky error flags
- w_done_flag, r_done_flag  out  1  frame fully written / fully read

## Operation
- Storage: 2^AD x DATA register array, with no reset on contents.
- Pointers: wptr and rptr are AD+1 bits.
  - level = wptr − rptr (modulo 2^(AD+1)).
  - Full = (level == 2^AD). Empty = (level == 0). All three are registered.
- Write:
  - Accepted when W_inc & ~Full. Stores mem[wptr[AD-1:0]] <= W_Data, then wptr+1 with natural wrap.
  - W_inc & Full: no store, overflow <= 1.
- Stream read (mode = 0):
  - Accepted when R_inc & ~Empty. R_Data <= mem[rptr[AD-1:0]], then rptr+1.
  - R_inc & Empty: underflow <= 1, R_valid stays 0.
- Direct read (mode = 1):
  - R_inc reads R_Data <= mem[fifo_address]. Never blocked by Empty.
  - rptr, level, underflow and r_done_flag are unaffected.
- r_addr_fifo = mode ? fifo_address : rptr[AD-1:0] (combinational).
- Simultaneous write and stream read: acceptance is decided on pre-edge Full/Empty.
  - Full with both requests: read only, level −1.
  - Empty with both requests: write only, level +1. No underflow, because R_inc & Empty sets underflow only when W_inc = 0.
  - Otherwise both are accepted and level is unchanged.
- Almost_full = (level >= af_level). Almost_empty = (level <= ae_level). Both are combinational from the level register.
- Frame tracking:
  - wr_words and rd_words are SIZE_W-bit counters that saturate at all-ones. They count accepted writes and accepted stream reads.
  - Bit counts = words << log2(DATA), computed in SIZE_W+log2(DATA) bits with no truncation.
  - w_done_flag <= 1 when wr_bits >= data_size and data_size != 0 (evaluated on the post-increment value). r_done_flag works the same way on rd_bits.
  - w_done_flag also clears when the FIFO becomes Empty after r_done_flag is set, ready for the next frame.
- tx_irq (synchronous, highest priority after RST) clears:
  - wptr, rptr and level
  - both word counters
  - both done flags
  - overflow, underflow and R_valid
  
  Requests in the same cycle as tx_irq are ignored.

## Timing
- Reset values:
  - Empty = 1, Almost_empty = 1 (when ae_level >= 0)
  - Full = 0, level = 0, R_valid = 0, R_Data = 0
  - overflow = 0, underflow = 0, w_done_flag = 0, r_done_flag = 0
- Write latency: status updates on the same edge that captures the write. Data is readable from the next cycle.
- Read latency: 1 cycle. R_Data and R_valid are updated on the edge after R_inc is sampled. R_valid is high for exactly one cycle per accepted read. R_Data holds its value otherwise.
- Back-to-back operations are supported at full throughput: one write and one read per cycle.
- Done flags assert on the edge that accepts the qualifying word.
- An RST assertion mid-frame clears everything asynchronously. Memory contents are undefined after reset.

## Test plan
- Reset: pulse RST mid-stream → Empty = 1, Full = 0, level = 0, all flags 0, R_valid = 0 immediately, without waiting for a clock edge.
- Fill/drain with AD = 3, DATA = 32:
  - Write 0x10..0x17 → Full = 1 and level = 8 after the 8th edge.
  - A 9th write → overflow = 1, level stays 8.
  - 8 reads → 0x10..0x17 in order, R_valid one cycle after each R_inc, then Empty = 1.
- Simultaneous operation:
  - At level 8, W_inc & R_inc → level 7, Full = 0.
  - At level 0, both → level 1, underflow = 0, R_valid = 0.
  - At level 4, both → level 4.
- Frame tracking with data_size = 100:
  - 3 writes (96 bits) → w_done_flag = 0. 4th write (128 bits) → w_done_flag = 1.
  - 4 reads → r_done_flag = 1, Empty = 1, then w_done_flag = 0.
  - tx_irq → all cleared.
- Peek: write 0xA0..0xA3, then mode = 1, fifo_address = 2, R_inc → R_Data = 0xA2, r_addr_fifo = 2, level stays 4. Then mode = 0, R_inc → R_Data = 0xA0, level = 3.
- Thresholds and wrap: af_level = 6, ae_level = 1. Run 20 interleaved writes and reads to wrap the pointers twice → Almost_full/Almost_empty track level exactly, and data order is preserved across the wrap.
